// File: rtl/screen_pkg.sv
// Shared display constants and the RGB444 pixel type for the screen pipeline.
package screen_pkg;

    localparam int H_RES         = 640;
    localparam int V_RES         = 480;
    localparam int LOGICAL_W     = 320;
    localparam int LOGICAL_H     = 240;
    localparam int WORDS_PER_ROW = 160;

    typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/screen_addr_calc.sv
// Combinational pixel coordinate -> {display-RAM word, half select, on-screen flag}.
module screen_addr_calc #(
    parameter int SCREEN_WIDTH = 11,
    parameter int ADDR_WIDTH   = 16,
    parameter int H_RES        = screen_pkg::H_RES,
    parameter int V_RES        = screen_pkg::V_RES
) (
    input  logic [SCREEN_WIDTH-1:0] x,
    input  logic [SCREEN_WIDTH-1:0] y,
    output logic [ADDR_WIDTH-1:0]   word,
    output logic                    sel,
    output logic                    valid
);

    logic [ADDR_WIDTH-1:0] ly;
    logic [ADDR_WIDTH-1:0] col;

    // ly*160 as two shifts; off-screen results may wrap but are masked downstream
    always_comb begin
        ly    = ADDR_WIDTH'(y[SCREEN_WIDTH-1:1]);
        col   = ADDR_WIDTH'(x[SCREEN_WIDTH-1:2]);
        word  = (ly << 7) + (ly << 5) + col;
        sel   = x[1];
        valid = (x < SCREEN_WIDTH'(H_RES)) && (y < SCREEN_WIDTH'(V_RES));
    end

endmodule

// File: rtl/get_screen_ram.sv
// Three-stage pixel fetch: coordinate -> RAM word address -> RGB444 colour.
// Optional debug grid overlay enabled by defining GET_SCREEN_RAM_GRID_EN.
module get_screen_ram #(
    parameter int                  SCREEN_WIDTH = 11,
    parameter int                  ADDR_WIDTH   = 16,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  H_RES        = screen_pkg::H_RES,
    parameter int                  V_RES        = screen_pkg::V_RES,
    parameter screen_pkg::rgb444_t BORDER_COLOR = 12'h000,
    parameter screen_pkg::rgb444_t GRID_COLOR   = 12'hFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCREEN_WIDTH-1:0]   x,
    input  logic [SCREEN_WIDTH-1:0]   y,
    output logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     data,
    output screen_pkg::rgb444_t       color
);

    logic [ADDR_WIDTH-1:0] word;
    logic                  sel;
    logic                  valid;
    logic                  sel_d1, valid_d1;
    logic                  sel_d2, valid_d2;
    screen_pkg::rgb444_t   ram_pix;
    screen_pkg::rgb444_t   color_next;

    screen_addr_calc #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .H_RES        (H_RES),
        .V_RES        (V_RES)
    ) u_addr_calc (
        .x     (x),
        .y     (y),
        .word  (word),
        .sel   (sel),
        .valid (valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            sel_d1   <= 1'b0;
            valid_d1 <= 1'b0;
            sel_d2   <= 1'b0;
            valid_d2 <= 1'b0;
        end else begin
            addr     <= valid ? word : '0;
            sel_d1   <= sel;
            valid_d1 <= valid;
            sel_d2   <= sel_d1;
            valid_d2 <= valid_d1;
        end
    end

`ifdef GET_SCREEN_RAM_GRID_EN
    logic grid, grid_d1, grid_d2;

    assign grid = (x[4:0] == 5'd0) || (y[4:0] == 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid_d1 <= 1'b0;
            grid_d2 <= 1'b0;
        end else begin
            grid_d1 <= grid;
            grid_d2 <= grid_d1;
        end
    end
`else
    // Tied off so the stage-3 mux folds away when the overlay is not built
    logic grid_d2;

    assign grid_d2 = 1'b0;
`endif

    always_comb begin
        ram_pix    = sel_d2 ? data[27:16] : data[11:0];
        color_next = BORDER_COLOR;
        if (valid_d2) begin
            color_next = grid_d2 ? GRID_COLOR : ram_pix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color <= '0;
        end else begin
            color <= color_next;
        end
    end

endmodule

// File: tb/tb_get_screen_ram.sv
// Scoreboard bench for get_screen_ram: expectations queued at drive time, checked on output.
module tb_get_screen_ram;

    localparam int SW = 11;
    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        int          due;
        logic [15:0] val;
        string       tag;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] x   = '0;
    logic [SW-1:0] y   = '0;
    logic [AW-1:0] addr;
    logic [DW-1:0] data = 32'h12345678;
    logic [11:0]   color;

    int  cyc      = 0;
    int  n_vec    = 0;
    int  n_miss   = 0;
    bit  ram_mode = 1'b0;
    sb_t addr_q[$];
    sb_t color_q[$];

    get_screen_ram #(
        .SCREEN_WIDTH (SW),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .H_RES        (640),
        .V_RES        (480),
        .BORDER_COLOR (12'h000),
        .GRID_COLOR   (12'hFFF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .addr  (addr),
        .data  (data),
        .color (color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    // Synchronous-read RAM model: data follows addr by one clock
    always @(posedge clk) data <= ram_mode ? ram_word(addr) : 32'h12345678;

    function automatic logic [15:0] model_addr(input int xi, input int yi);
        if (xi < 640 && yi < 480) return 16'((yi / 2) * 160 + xi / 4);
        return 16'h0000;
    endfunction

    function automatic logic [11:0] model_color(input int xi, input int yi, input bit rm);
        logic [31:0] w;
        if (!(xi < 640 && yi < 480)) return 12'h000;
        w = rm ? ram_word(model_addr(xi, yi)) : 32'h12345678;
        return ((xi / 2) % 2 == 1) ? w[27:16] : w[11:0];
    endfunction

    always @(negedge clk) begin
        sb_t e;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            n_vec++;
            if (addr !== e.val) begin
                n_miss++;
                $display("FAIL addr %s: got %h expected %h", e.tag, addr, e.val);
            end
        end
        while (color_q.size() > 0 && color_q[0].due <= cyc) begin
            e = color_q.pop_front();
            n_vec++;
            if (color !== e.val[11:0]) begin
                n_miss++;
                $display("FAIL color %s: got %h expected %h", e.tag, color, e.val[11:0]);
            end
        end
    end

    // Call right after a negedge: queue expectations, then drive the coordinate
    task automatic push(input int xi, input int yi, input logic [15:0] ea,
                        input logic [11:0] ec, input string tag);
        addr_q.push_back('{cyc + 1, ea, tag});
        color_q.push_back('{cyc + 3, {4'h0, ec}, tag});
        x = SW'(xi);
        y = SW'(yi);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (addr_q.size() + color_q.size()) > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if ((addr_q.size() + color_q.size()) > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d outputs never seen, expected 0", addr_q.size() + color_q.size());
            addr_q.delete();
            color_q.delete();
        end
    endtask

    task automatic test_reset();
        x = 11'd100;
        y = 11'd100;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (addr !== 16'h0000) begin
            n_miss++;
            $display("FAIL reset_addr: got %h expected 0000", addr);
        end
        n_vec++;
        if (color !== 12'h000) begin
            n_miss++;
            $display("FAIL reset_color: got %h expected 000", color);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_table();
        @(negedge clk); push(11'h100, 11'h078, 16'h25C0, 12'h678, "t100_078"); drain();
        @(negedge clk); push(11'h101, 11'h072, 16'h23E0, 12'h678, "t101_072"); drain();
        @(negedge clk); push(11'h103, 11'h085, 16'h2980, 12'h234, "t103_085"); drain();
    endtask

    task automatic test_boundary();
        @(negedge clk); push(640, 10, 16'h0000, 12'h000, "x640");
        @(negedge clk); push(639, 479, 16'h95FF, 12'h234, "x639_y479");
        @(negedge clk); push(10, 480, 16'h0000, 12'h000, "y480");
        @(negedge clk); push(0, 0, 16'h0000, 12'h678, "origin");
        @(negedge clk); push(11'h7FF, 5, 16'h0000, 12'h000, "xmax");
        @(negedge clk); push(5, 11'h7FF, 16'h0000, 12'h000, "ymax");
        @(negedge clk); push(2, 1, 16'h0000, 12'h234, "x2_sel1");
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); push(11'h100, 11'h078, 16'h25C0, 12'h678, "b2b0");
        @(negedge clk); push(11'h101, 11'h072, 16'h23E0, 12'h678, "b2b1");
        @(negedge clk); push(11'h103, 11'h085, 16'h2980, 12'h234, "b2b2");
        drain();
    endtask

    task automatic test_ram_stream();
        int xi, yi;
        ram_mode = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            xi = int'($urandom_range(0, 700));
            yi = int'($urandom_range(0, 520));
            @(negedge clk);
            push(xi, yi, model_addr(xi, yi), model_color(xi, yi, 1'b1), "ram_stream");
        end
        drain();
        ram_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk); push(11'h100, 11'h078, 16'h25C0, 12'h678, "pre_rst0");
        @(negedge clk); push(11'h103, 11'h085, 16'h2980, 12'h234, "pre_rst1");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        addr_q.delete();
        color_q.delete();
        n_vec++;
        if (addr !== 16'h0000) begin
            n_miss++;
            $display("FAIL midrst_addr: got %h expected 0000", addr);
        end
        n_vec++;
        if (color !== 12'h000) begin
            n_miss++;
            $display("FAIL midrst_color: got %h expected 000", color);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); push(11'h101, 11'h072, 16'h23E0, 12'h678, "post_rst");
        drain();
    endtask

    initial begin
        test_reset();
        test_table();
        test_boundary();
        test_back_to_back();
        test_ram_stream();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at 200000, expected completion");
        $fatal(1);
    end

endmodule
